// File: rtl/conv_window_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_fetch_if
//  Description : Bus bundle for conv_window_fetch. Carries the single-word
//                read handshake toward the input-feature BRAM wrapper
//                (rd_en/rd_addr/rd_valid/rd_data) and the packed 3x3 window
//                stream toward the MAC array
//                (win_data/win_valid/win_ready/win_last).
//                master : the window fetcher
//                slave  : the environment (BRAM wrapper + MAC array)
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_window_fetch_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_valid;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [9*DATA_WIDTH-1:0] win_data;
    logic                    win_valid;
    logic                    win_ready;
    logic                    win_last;

    modport master (
        output rd_en, rd_addr,
        input  rd_valid, rd_data,
        output win_data, win_valid, win_last,
        input  win_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_valid, rd_data,
        input  win_data, win_valid, win_last,
        output win_ready
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_fetch
//  Description : Walks an image stored in the input-feature BRAM row-major,
//                fetching one word at a time, and assembles 3x3 windows for
//                the MAC array. Tap t = kr*3+kc sits at
//                win_data[t*DATA_WIDTH +: DATA_WIDTH].
//  Ports       : iclk, irst (async, active high)
//                start / base_addr : frame start pulse and pixel (0,0) address
//                bus (master)      : BRAM read handshake + window stream
//                busy / done       : frame in progress / end-of-frame pulse
//  Options     : WIN_ZERO_PAD_EN - same-size output with 1-pixel zero
//                padding; out-of-image taps are filled without a BRAM read.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32
) (
    input  wire logic                  iclk,
    input  wire logic                  irst,
    input  wire logic                  start,
    input  wire logic [ADDR_WIDTH-1:0] base_addr,
    conv_window_fetch_if.master        bus,
    output logic                       busy,
    output logic                       done
);

    localparam int c_row_w = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;

`ifdef WIN_ZERO_PAD_EN
    localparam int c_row_last_i = IMG_H - 1;
    localparam int c_col_last_i = IMG_W - 1;
`else
    localparam int c_row_last_i = IMG_H - 3;
    localparam int c_col_last_i = IMG_W - 3;
`endif

    localparam logic [c_row_w-1:0]    c_row_last = c_row_w'(c_row_last_i);
    localparam logic [c_col_w-1:0]    c_col_last = c_col_w'(c_col_last_i);
    localparam logic [3:0]            c_tap_last = 4'd8;
    localparam logic [ADDR_WIDTH-1:0] c_img_w_a  = ADDR_WIDTH'(IMG_W);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_req  = 3'd1;
    localparam logic [2:0] c_st_wait = 3'd2;
    localparam logic [2:0] c_st_out  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [c_row_w-1:0]      r_row;
    logic [c_col_w-1:0]      r_col;
    logic [3:0]              r_tap;
    logic [9*DATA_WIDTH-1:0] r_window;

    logic [1:0]              w_kr;
    logic [1:0]              w_kc;
    logic [ADDR_WIDTH-1:0]   w_pix_row;
    logic [ADDR_WIDTH-1:0]   w_pix_col;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_skip;
    logic                    w_row_end;
    logic                    w_col_end;
    logic                    w_last_pos;

    // Tap index -> kernel row/column.
    always_comb begin
        w_kr = 2'd0;
        w_kc = 2'd0;
        case (r_tap)
            4'd1:    begin w_kr = 2'd0; w_kc = 2'd1; end
            4'd2:    begin w_kr = 2'd0; w_kc = 2'd2; end
            4'd3:    begin w_kr = 2'd1; w_kc = 2'd0; end
            4'd4:    begin w_kr = 2'd1; w_kc = 2'd1; end
            4'd5:    begin w_kr = 2'd1; w_kc = 2'd2; end
            4'd6:    begin w_kr = 2'd2; w_kc = 2'd0; end
            4'd7:    begin w_kr = 2'd2; w_kc = 2'd1; end
            4'd8:    begin w_kr = 2'd2; w_kc = 2'd2; end
            default: begin w_kr = 2'd0; w_kc = 2'd0; end
        endcase
    end

`ifdef WIN_ZERO_PAD_EN
    // Window is centred on (row,col): source pixel is (row+kr-1, col+kc-1).
    // The sums are kept one above the pixel index so "-1" never goes
    // negative; a sum of 0 or above the image size is a padding tap.
    localparam logic [c_row_w+1:0] c_row_lim = (c_row_w+2)'(IMG_H);
    localparam logic [c_col_w+1:0] c_col_lim = (c_col_w+2)'(IMG_W);

    logic [c_row_w+1:0] w_sum_r;
    logic [c_col_w+1:0] w_sum_c;

    assign w_sum_r   = {2'b00, r_row} + {{c_row_w{1'b0}}, w_kr};
    assign w_sum_c   = {2'b00, r_col} + {{c_col_w{1'b0}}, w_kc};
    assign w_skip    = (w_sum_r == '0) || (w_sum_r > c_row_lim) ||
                       (w_sum_c == '0) || (w_sum_c > c_col_lim);
    assign w_pix_row = ADDR_WIDTH'(w_sum_r) - ADDR_WIDTH'(1);
    assign w_pix_col = ADDR_WIDTH'(w_sum_c) - ADDR_WIDTH'(1);
`else
    assign w_skip    = 1'b0;
    assign w_pix_row = ADDR_WIDTH'(r_row) + ADDR_WIDTH'(w_kr);
    assign w_pix_col = ADDR_WIDTH'(r_col) + ADDR_WIDTH'(w_kc);
`endif

    // Address arithmetic wraps modulo 2^ADDR_WIDTH on purpose.
    assign w_addr     = r_base + w_pix_row * c_img_w_a + w_pix_col;
    assign w_row_end  = (r_row == c_row_last);
    assign w_col_end  = (r_col == c_col_last);
    assign w_last_pos = w_row_end && w_col_end;

    // ---------------------------------------------------------------- state
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) w_state_nxt = c_st_req;
            end
            c_st_req: begin
                // A padding tap is resolved in REQ itself, one tap per cycle.
                if (!w_skip)                  w_state_nxt = c_st_wait;
                else if (r_tap == c_tap_last) w_state_nxt = c_st_out;
            end
            c_st_wait: begin
                if (bus.rd_valid)
                    w_state_nxt = (r_tap == c_tap_last) ? c_st_out : c_st_req;
            end
            c_st_out: begin
                if (bus.win_ready)
                    w_state_nxt = w_last_pos ? c_st_done : c_st_req;
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.win_valid = 1'b0;
        bus.win_last  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            c_st_req: begin
                bus.rd_en   = ~w_skip;
                bus.rd_addr = w_skip ? '0 : w_addr;
                busy        = 1'b1;
            end
            c_st_wait: begin
                bus.rd_addr = w_addr;
                busy        = 1'b1;
            end
            c_st_out: begin
                bus.win_valid = 1'b1;
                bus.win_last  = w_last_pos;
                busy          = 1'b1;
            end
            c_st_done: done = 1'b1;
            default: ;
        endcase
    end

    assign bus.win_data = r_window;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_base   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_tap    <= '0;
            r_window <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_row  <= '0;
                        r_col  <= '0;
                        r_tap  <= '0;
                    end
                end
                c_st_req: begin
                    if (w_skip) begin
                        r_window[r_tap*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        if (r_tap != c_tap_last) r_tap <= r_tap + 4'd1;
                    end
                end
                c_st_wait: begin
                    if (bus.rd_valid) begin
                        r_window[r_tap*DATA_WIDTH +: DATA_WIDTH] <= bus.rd_data;
                        if (r_tap != c_tap_last) r_tap <= r_tap + 4'd1;
                    end
                end
                c_st_out: begin
                    if (bus.win_ready) begin
                        r_tap <= '0;
                        if (!w_col_end) begin
                            r_col <= r_col + c_col_w'(1);
                        end else begin
                            r_col <= '0;
                            if (!w_row_end) r_row <= r_row + c_row_w'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_conv_window_fetch
//  Description : Self-checking bench for conv_window_fetch on a 4x4 image.
//                A BRAM model returns data = address two cycles after rd_en.
//                Expected windows are queued when a frame is started and
//                popped as windows are handshaken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_fetch;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int W  = 4;
    localparam int H  = 4;
`ifdef WIN_ZERO_PAD_EN
    localparam int NR  = H;
    localparam int NC  = W;
    localparam int OFS = 1;
`else
    localparam int NR  = H - 2;
    localparam int NC  = W - 2;
    localparam int OFS = 0;
`endif
    localparam int NWIN = NR * NC;

    typedef struct packed {
        logic [9*DW-1:0] data;
        logic [9*AW-1:0] addrs;
        logic            last;
        logic [3:0]      reads;
    } exp_t;

    exp_t sb[$];

    logic          iclk = 1'b0;
    logic          irst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    conv_window_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    conv_window_fetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(W), .IMG_H(H)
    ) dut (
        .iclk(iclk), .irst(irst), .start(start), .base_addr(base_addr),
        .bus(bus), .busy(busy), .done(done)
    );

    always #5 iclk = ~iclk;

    // BRAM model: word = address, valid two cycles after the request edge.
    logic          m_v1;
    logic [AW-1:0] m_a1;
    always @(posedge iclk or posedge irst) begin
        if (irst) begin
            m_v1         <= 1'b0;
            m_a1         <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            m_v1         <= bus.rd_en;
            m_a1         <= bus.rd_addr;
            bus.rd_valid <= m_v1;
            bus.rd_data  <= DW'(m_a1);
        end
    end

    // Read monitor.
    int            rd_cnt    = 0;
    int            rd_in_out = 0;
    int            rd_mark   = 0;
    logic [AW-1:0] rd_log[$];
    always @(posedge iclk) begin
        if (!irst && bus.rd_en) begin
            rd_cnt = rd_cnt + 1;
            rd_log.push_back(bus.rd_addr);
            if (bus.win_valid) rd_in_out = rd_in_out + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference model for the window at walk position (r,c).
    function automatic exp_t make_exp(input logic [AW-1:0] base, input int r, input int c);
        exp_t          e;
        int            pr, pc, n;
        logic [AW-1:0] a;
        e = '0;
        n = 0;
        for (int t = 0; t < 9; t++) begin
            pr = r + t / 3 - OFS;
            pc = c + t % 3 - OFS;
            if (pr >= 0 && pr < H && pc >= 0 && pc < W) begin
                a = base + AW'(pr * W + pc);
                e.data[t*DW +: DW] = DW'(a);
                e.addrs[n*AW +: AW] = a;
                n++;
            end
        end
        e.reads = 4'(n);
        e.last  = (r == NR - 1) && (c == NC - 1);
        return e;
    endfunction

    task automatic do_start(input logic [AW-1:0] b);
        sb.delete();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                sb.push_back(make_exp(b, r, c));
        rd_mark   = rd_cnt;
        base_addr = b;
        start     = 1'b1;
        @(negedge iclk);
        start     = 1'b0;
    endtask

    // Waits (bounded) for win_valid and samples the window; no comparison.
    task automatic collect_window(output exp_t got, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.win_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge iclk);
        end
        got       = '0;
        got.data  = bus.win_data;
        got.last  = bus.win_last;
        got.reads = 4'(rd_cnt - rd_mark);
        rd_mark   = rd_cnt;
    endtask

    task automatic test_reset;
        irst          = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        bus.win_ready = 1'b0;
        repeat (3) @(negedge iclk);
        irst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge iclk);
            checks++;
            if ({bus.rd_en, bus.win_valid, bus.win_last, busy, done} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl cycle %0d: got %b want 00000", i,
                         {bus.rd_en, bus.win_valid, bus.win_last, busy, done});
            end
        end
        checks++;
        if (bus.win_data !== '0 || bus.rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_data: win_data=%h rd_addr=%h want 0", bus.win_data, bus.rd_addr);
        end
        checks++;
        if (rd_cnt !== 0) begin
            errors++;
            $display("FAIL reset_reads: got %0d want 0", rd_cnt);
        end
    endtask

    task automatic test_basic_frame;
        exp_t got, exp;
        bit   ok;
        int   extra;
        bus.win_ready = 1'b1;
        do_start(16'h0000);
        for (int k = 0; k < NWIN; k++) begin
            collect_window(got, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL basic_timeout window %0d: no win_valid", k);
                break;
            end
            exp = sb.pop_front();
            checks++;
            if (got.data !== exp.data) begin
                errors++;
                $display("FAIL basic_data w%0d: got %h want %h", k, got.data, exp.data);
            end
            checks++;
            if (got.last !== exp.last || got.reads !== exp.reads) begin
                errors++;
                $display("FAIL basic_last_reads w%0d: got %b/%0d want %b/%0d",
                         k, got.last, got.reads, exp.last, exp.reads);
            end
`ifndef WIN_ZERO_PAD_EN
            if (k == 0) begin
                checks++;
                if (got.data !== {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0}) begin
                    errors++;
                    $display("FAIL basic_first_literal: got %h", got.data);
                end
            end
            if (k == NWIN - 1) begin
                checks++;
                if (got.data !== {16'd15, 16'd14, 16'd13, 16'd11, 16'd10, 16'd9, 16'd7, 16'd6, 16'd5}) begin
                    errors++;
                    $display("FAIL basic_last_literal: got %h", got.data);
                end
            end
`else
            if (k == 0) begin
                checks++;
                if (got.data !== {16'd5, 16'd4, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}
                    || got.reads !== 4'd4) begin
                    errors++;
                    $display("FAIL pad_corner_literal: got %h reads %0d", got.data, got.reads);
                end
            end
`endif
            @(negedge iclk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b want 1/0", done, busy);
        end
        @(negedge iclk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b want 0", done);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.win_valid || busy) extra++;
            @(negedge iclk);
        end
        checks++;
        if (extra !== 0 || sb.size() !== 0 || rd_in_out !== 0) begin
            errors++;
            $display("FAIL basic_count: extra=%0d left=%0d rd_in_out=%0d want 0/0/0",
                     extra, sb.size(), rd_in_out);
        end
    endtask

    task automatic test_backpressure;
        exp_t            got, exp;
        bit              ok;
        logic [9*DW-1:0] held;
        bus.win_ready = 1'b1;
        do_start(16'h0000);
        for (int k = 0; k < NWIN; k++) begin
            collect_window(got, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL bp_timeout window %0d", k);
                break;
            end
            exp = sb.pop_front();
            checks++;
            if (got.data !== exp.data || got.last !== exp.last) begin
                errors++;
                $display("FAIL bp_data w%0d: got %h/%b want %h/%b", k, got.data, got.last, exp.data, exp.last);
            end
            if (k == 1) begin
                held = got.data;
                for (int i = 0; i < 10; i++) begin
                    @(negedge iclk);
                    checks++;
                    if (bus.win_valid !== 1'b1 || bus.win_data !== held || bus.rd_en !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold cycle %0d: valid=%b data=%h rd_en=%b want 1/%h/0",
                                 i, bus.win_valid, bus.win_data, bus.rd_en, held);
                    end
                end
                bus.win_ready = 1'b1;
            end
            @(negedge iclk);
            if (k == 0) bus.win_ready = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || sb.size() !== 0) begin
            errors++;
            $display("FAIL bp_done: done=%b left=%0d want 1/0", done, sb.size());
        end
        repeat (3) @(negedge iclk);
    endtask

    task automatic test_start_busy_wrap;
        exp_t got, exp;
        bit   ok;
        int   log0, extra;
        bus.win_ready = 1'b1;
        log0 = rd_log.size();
        do_start(16'hFFFE);
        exp = sb[0];
        for (int k = 0; k < NWIN; k++) begin
            collect_window(got, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL wrap_timeout window %0d", k);
                break;
            end
            exp = sb.pop_front();
            checks++;
            if (got.data !== exp.data || got.last !== exp.last) begin
                errors++;
                $display("FAIL wrap_data w%0d: got %h/%b want %h/%b", k, got.data, got.last, exp.data, exp.last);
            end
            if (k == 0) begin
                for (int j = 0; j < 3; j++) begin
                    checks++;
                    if (rd_log[log0 + j] !== exp.addrs[j*AW +: AW]) begin
                        errors++;
                        $display("FAIL wrap_addr %0d: got %h want %h", j, rd_log[log0 + j], exp.addrs[j*AW +: AW]);
                    end
                end
`ifndef WIN_ZERO_PAD_EN
                checks++;
                if (rd_log[log0] !== 16'hFFFE || rd_log[log0 + 1] !== 16'hFFFF || rd_log[log0 + 2] !== 16'h0000) begin
                    errors++;
                    $display("FAIL wrap_literal: got %h %h %h want fffe ffff 0000",
                             rd_log[log0], rd_log[log0 + 1], rd_log[log0 + 2]);
                end
`endif
                // Start pulses while busy: one during OUT, one a few cycles later.
                base_addr = 16'h1234;
                start     = 1'b1;
                @(negedge iclk);
                start     = 1'b0;
                repeat (4) @(negedge iclk);
                start     = 1'b1;
                @(negedge iclk);
                start     = 1'b0;
            end else begin
                @(negedge iclk);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: done=%b busy=%b want 1/0", done, busy);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge iclk);
            if (bus.win_valid || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_start_ignored: extra activity %0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid_frame;
        exp_t got, exp;
        bit   ok, seen;
        int   bad;
        bus.win_ready = 1'b1;
        do_start(16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rd_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge iclk);
        end
        @(negedge iclk);
        checks++;
        if (!seen || busy !== 1'b1 || bus.rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_wait: seen=%b busy=%b rd_en=%b want 1/1/0", seen, busy, bus.rd_en);
        end
        irst = 1'b1;
        #1;
        checks++;
        if ({busy, done, bus.rd_en, bus.win_valid} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_abort: got %b want 0000", {busy, done, bus.rd_en, bus.win_valid});
        end
        @(negedge iclk);
        irst = 1'b0;
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge iclk);
            if (done || busy || bus.rd_en) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: active cycles %0d want 0", bad);
        end
        do_start(16'h0000);
        for (int k = 0; k < NWIN; k++) begin
            collect_window(got, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL restart_timeout window %0d", k);
                break;
            end
            exp = sb.pop_front();
            checks++;
            if (got.data !== exp.data || got.last !== exp.last || got.reads !== exp.reads) begin
                errors++;
                $display("FAIL restart_data w%0d: got %h/%b/%0d want %h/%b/%0d",
                         k, got.data, got.last, got.reads, exp.data, exp.last, exp.reads);
            end
            @(negedge iclk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: done=%b want 1", done);
        end
        repeat (3) @(negedge iclk);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_start_busy_wrap();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Sits directly downstream of the input-feature BRAM wrapper in the convolution IP.
- Walks a stored image row-major and issues one single-word read at a time on the wrapper's enb/addrb/valid/doutb handshake.
- Assembles each 3x3 window and presents it to the MAC array as a packed 9-tap word with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, pixel width; matches the BRAM wrapper data width.
- ADDR_WIDTH, 16, read address width; matches the BRAM wrapper addrb width.
- IMG_W, 32, image width in pixels, >= 3.
- IMG_H, 32, image height in pixels, >= 3.

Ports:
- iclk  in  1  clock; all logic on the rising edge.
- irst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a frame; sampled only while busy=0.
- base_addr  in  ADDR_WIDTH  BRAM address of pixel (0,0); captured on an accepted start.
- rd_en  out  1  read request pulse to the wrapper's enb.
- rd_addr  out  ADDR_WIDTH  read address to the wrapper's addrb.
- rd_valid  in  1  wrapper valid; rd_data is good this cycle.
- rd_data  in  DATA_WIDTH  wrapper doutb.
- win_data  out  9*DATA_WIDTH  tap t = kr*3+kc at [t*DATA_WIDTH +: DATA_WIDTH]; tap 0 in the LSBs.
- win_valid  out  1  window available.
- win_ready  in  1  consumer accepts the window.
- win_last  out  1  qualifies the final window of the frame.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse after the last window handshake.

Behaviour:
- Reset (async, irst=1): state=IDLE; all outputs 0; row/col/tap counters 0; window register cleared.
- State machine:
  - IDLE: on start, capture base_addr, clear row/col/tap, set busy -> REQ.
  - REQ: rd_en=1 for exactly one cycle; rd_addr = base + (row+kr)*IMG_W + (col+kc), where kr=tap/3 and kc=tap%3; arithmetic is modulo 2^ADDR_WIDTH, wrap allowed -> WAIT_RD.
  - WAIT_RD: rd_en=0; rd_addr held stable. On rd_valid, store rd_data in slot tap. If tap==8 -> OUT; else tap+1 -> REQ.
  - OUT: win_valid=1; win_data and win_last held stable until win_ready. On win_valid & win_ready, tap clears and the walk advances:
    - col < IMG_W-3: col+1 -> REQ.
    - col == IMG_W-3 and row < IMG_H-3: col=0, row+1 -> REQ.
    - col == IMG_W-3 and row == IMG_H-3 (last window) -> DONE.
  - DONE: done=1 and busy=0 in this cycle -> IDLE.
- One read outstanding at most. The next rd_en is issued no earlier than the cycle after rd_valid, which satisfies the wrapper's READ->IDLE return.
- Window count per frame is (IMG_W-2)*(IMG_H-2).
- win_last=1 only with win_valid for window (IMG_H-3, IMG_W-3).
- No new read is issued while in OUT; backpressure stalls the whole block.
- rd_valid outside WAIT_RD is ignored.
- start while busy=1 is ignored; base_addr is not re-captured.
- Reset mid-frame aborts immediately; no done pulse; the next start begins a fresh frame.
- Per-window cost is 9*(1 + wrapper latency + 1) cycles plus the OUT cycles; no overlap between windows.

Optional Feature:
- Macro: WIN_ZERO_PAD_EN.
- Defined (same-size output, 1-pixel zero padding):
  - Windows are centred on every pixel: row 0..IMG_H-1, col 0..IMG_W-1; IMG_W*IMG_H windows per frame.
  - Tap source pixel is (row+kr-1, col+kc-1).
  - Out-of-image taps skip REQ/WAIT_RD entirely: slot written 0, tap advances in one cycle, no rd_en.
  - win_last qualifies window (IMG_H-1, IMG_W-1).
- Undefined: valid-only windows exactly as in Behaviour; no padding logic synthesised.

Test Plan:
- Reset/idle: assert irst, then idle 5 cycles -> all outputs 0, no rd_en.
- Basic window: IMG_W=IMG_H=4, memory word = address, base_addr=0, start -> first window taps 0,1,2,4,5,6,8,9,10; 9 rd_en pulses; exactly 4 windows in total.
- Last window and done: same setup -> 4th window is 5,6,7,9,10,11,13,14,15 with win_last=1; done pulses one cycle after its handshake; busy then 0.
- Backpressure: win_ready=0 for 10 cycles on window 2 -> win_valid held, win_data stable, rd_en=0 throughout; resumes on win_ready=1.
- Start while busy and address wrap: start pulse mid-frame -> ignored, window count unchanged. base_addr=16'hFFFE -> first tap addresses FFFE, FFFF, 0000.
- Reset mid-frame and padding: irst during WAIT_RD -> IDLE, no done, clean restart. WIN_ZERO_PAD_EN defined, 4x4 image -> 16 windows; window (0,0) = 0,0,0,0,0,1,0,4,5 with only 4 rd_en pulses.
